md_unit: RTL and testbench

Iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU. It sits in the EX stage beside the ALU and receives operands plus the decode controls `md_is_mult` and `md_is_unsigned`. It owns the architectural HI/LO registers and serves MFHI/MFLO reads. While a result is pending it stalls the pipeline.

---
 rtl/md_unit_pkg.sv | 21 ++
 rtl/md_lohi_reg.sv | 34 +++
 rtl/md_unit.sv | 167 ++++++++++++++++
 tb/tb_md_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   - md_state_e : FSM state encoding (MD_IDLE, MD_CALC, MD_FIX)
//   - MD_ITER    : number of shift-add / restoring-divide iterations
//   - MD_DIVZ_LO : LO value written by a divide by zero
//   - md_abs     : operand magnitude helper (abs when signed, raw when unsigned)
package md_unit_pkg;

    localparam int unsigned MD_ITER    = 32;
    localparam logic [31:0] MD_DIVZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_lohi_reg.sv
// md_lohi_reg: architectural HI/LO register pair with a single write port and
// a combinational read mux.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (HI = LO = 0)
//   wen_i          : write HI and LO this cycle
//   hi_i, lo_i     : write data
//   is_hi_i        : read select, 1 = HI, 0 = LO
//   rdata_o        : read data
module md_lohi_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        is_hi_i,
    output logic [31:0] rdata_o
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (wen_i) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    assign rdata_o = is_hi_i ? hi_q : lo_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   md_start                : launch an operation (accepted only when idle)
//   md_is_mult              : 1 = multiply, 0 = divide
//   md_is_unsigned          : 1 = MULTU/DIVU
//   op_a, op_b              : rs (multiplicand/dividend), rt (multiplier/divisor)
//   lhr_ren, lhr_is_hi      : MFHI/MFLO read request and select
//   rdata                   : HI or LO read data (combinational)
//   busy                    : operation in flight
//   done                    : one-cycle pulse in the cycle HI/LO are written
//   stall                   : freeze IF/ID/EX
// Configuration: define MD_DIV_EN to include the divider. Without it, a divide
// start goes straight to FIX and leaves HI/LO unchanged.
module md_unit
    import md_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic        md_is_mult,
    input  logic        md_is_unsigned,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        lhr_ren,
    input  logic        lhr_is_hi,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [4:0] LastIter = 5'(MD_ITER - 1);

    md_state_e   state_q;
    logic        is_mult_q;
    logic        neg_res_q;
    logic        done_q;
    logic [4:0]  count_q;
    logic [31:0] op_q;      // multiplicand (mult) or divisor (div) magnitude
    logic [31:0] acc_hi_q;  // product high half / partial remainder
    logic [31:0] acc_lo_q;  // multiplier being shifted out / dividend-to-quotient
`ifdef MD_DIV_EN
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
`endif

    logic [32:0] mul_sum;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic        wen;
    logic [31:0] wr_hi, wr_lo;

    // One iteration of the shift-add multiplier or restoring divider.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], acc_lo_q[31:1]};
`ifdef MD_DIV_EN
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_trial = div_shift - {1'b0, op_q};
        if (!is_mult_q) begin
            if (div_shift >= {1'b0, op_q}) begin
                step_hi = div_trial[31:0];
                step_lo = {acc_lo_q[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {acc_lo_q[30:0], 1'b0};
            end
        end
`endif
    end

    // Sign fix-up and HI/LO write in the FIX cycle.
    always_comb begin
        prod_fix = neg_res_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};
        wen      = (state_q == MD_FIX) && is_mult_q;
        wr_hi    = prod_fix[63:32];
        wr_lo    = prod_fix[31:0];
`ifdef MD_DIV_EN
        if (!is_mult_q) begin
            wen   = (state_q == MD_FIX);
            wr_hi = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
            // Divisor 0 leaves |a| as remainder, so HI restores to op_a naturally.
            wr_lo = div_zero_q ? MD_DIVZ_LO :
                    (neg_res_q ? (~acc_lo_q + 32'd1) : acc_lo_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            is_mult_q  <= 1'b0;
            neg_res_q  <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 5'd0;
            op_q       <= 32'd0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
`ifdef MD_DIV_EN
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        is_mult_q <= md_is_mult;
                        neg_res_q <= !md_is_unsigned && (op_a[31] ^ op_b[31]);
                        op_q      <= md_is_mult ? md_abs(op_a, !md_is_unsigned)
                                                : md_abs(op_b, !md_is_unsigned);
                        acc_hi_q  <= 32'd0;
                        acc_lo_q  <= md_is_mult ? md_abs(op_b, !md_is_unsigned)
                                                : md_abs(op_a, !md_is_unsigned);
                        count_q   <= 5'd0;
`ifdef MD_DIV_EN
                        neg_rem_q  <= !md_is_unsigned && op_a[31];
                        div_zero_q <= (op_b == 32'd0);
                        state_q    <= MD_CALC;
`else
                        if (md_is_mult) begin
                            state_q <= MD_CALC;
                        end else begin
                            state_q <= MD_FIX;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end
                MD_CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    count_q  <= count_q + 5'd1;
                    if (count_q == LastIter) begin
                        state_q <= MD_FIX;
                        done_q  <= 1'b1;
                    end
                end
                MD_FIX: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    md_lohi_reg u_lohi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen_i   (wen),
        .hi_i    (wr_hi),
        .lo_i    (wr_lo),
        .is_hi_i (lhr_is_hi),
        .rdata_o (rdata)
    );

    assign busy  = (state_q != MD_IDLE);
    assign done  = done_q;
    assign stall = busy && (md_start || lhr_ren);

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start, md_is_mult, md_is_unsigned;
    logic [31:0] op_a, op_b;
    logic        lhr_ren, lhr_is_hi;
    logic [31:0] rdata;
    logic        busy, done, stall;

    md_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .md_start       (md_start),
        .md_is_mult     (md_is_mult),
        .md_is_unsigned (md_is_unsigned),
        .op_a           (op_a),
        .op_b           (op_b),
        .lhr_ren        (lhr_ren),
        .lhr_is_hi      (lhr_is_hi),
        .rdata          (rdata),
        .busy           (busy),
        .done           (done),
        .stall          (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

`ifdef MD_DIV_EN
    localparam int DivLat = 33;
`else
    localparam int DivLat = 1;
`endif

    task automatic push_exp(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input int lat);
        exp_t e;
        e.name = name; e.hi = hi; e.lo = lo; e.lat = lat;
        sb.push_back(e);
        model_hi = hi;
        model_lo = lo;
    endtask

    // Expected values for a divide, honouring the build configuration.
    task automatic push_div(input string name, input logic [31:0] hi, input logic [31:0] lo);
`ifdef MD_DIV_EN
        push_exp(name, hi, lo, DivLat);
`else
        push_exp(name, model_hi, model_lo, DivLat);
`endif
    endtask

    // Drive a start at the current (non-edge) time; returns just after edge 0.
    task automatic issue(input logic mult, input logic uns, input logic [31:0] a,
                         input logic [31:0] b);
        md_start = 1'b1; md_is_mult = mult; md_is_unsigned = uns; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        md_start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; lat = 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result();
        int   lat;
        exp_t e;
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", e.name, lat, e.lat);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_in_fix: got %b expected 1", e.name, busy);
        end
        @(negedge clk);
        lhr_is_hi = 1'b1;
        #1;
        checks++;
        if (rdata !== e.hi) begin
            failures++;
            $display("FAIL %s hi: got %h expected %h", e.name, rdata, e.hi);
        end
        lhr_is_hi = 1'b0;
        #1;
        checks++;
        if (rdata !== e.lo) begin
            failures++;
            $display("FAIL %s lo: got %h expected %h", e.name, rdata, e.lo);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after: got %b expected 0", e.name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; md_start = 1'b0; md_is_mult = 1'b0; md_is_unsigned = 1'b0;
        op_a = 32'd0; op_b = 32'd0; lhr_ren = 1'b0; lhr_is_hi = 1'b0;
        #12;
        checks++;
        if ({busy, done, stall} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/stall=%b expected 000", {busy, done, stall});
        end
        checks++;
        if (rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_lo: got %h expected 0", rdata);
        end
        lhr_is_hi = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_hi: got %h expected 0", rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [31:0] a, b;
        logic [63:0] p;
        push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 33);
        issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_result();
        push_exp("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        issue(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        check_result();
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom;
            p = {32'd0, a} * {32'd0, b};
            push_exp("multu_rand", p[63:32], p[31:0], 33);
            issue(1'b1, 1'b1, a, b);
            check_result();
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            push_exp("mult_rand", p[63:32], p[31:0], 33);
            issue(1'b1, 1'b0, a, b);
            check_result();
        end
    endtask

    task automatic test_div();
        push_div("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        check_result();
        push_div("divu_100_7", 32'd2, 32'd14);
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        check_result();
        push_div("div_5_0", 32'd5, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 32'd5, 32'd0);
        check_result();
        push_div("div_m5_0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 32'hFFFF_FFFB, 32'd0);
        check_result();
        push_div("div_ovf", 32'd0, 32'h8000_0000);
        issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check_result();
        // Leave HI/LO non-zero for the mid-operation reset test.
        push_exp("mult_seed", 32'd0, 32'd99, 33);
        issue(1'b1, 1'b1, 32'd9, 32'd11);
        check_result();
    endtask

    task automatic test_mflo_stall();
        int   bad = 0;
        int   done_at = 0;
        exp_t e;
        push_exp("mflo_6x7", 32'd0, 32'd42, 33);
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 5) begin
                lhr_ren = 1'b1;
                lhr_is_hi = 1'b0;
            end
            #1;
            if (c == 2) begin
                checks++;
                if (stall !== 1'b0) begin
                    failures++;
                    $display("FAIL indep_no_stall: got %b expected 0", stall);
                end
            end
            if (c >= 5 && stall !== 1'b1) bad++;
            if (done === 1'b1 && done_at == 0) done_at = c;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mflo_stall_held: got %0d unstalled cycles expected 0", bad);
        end
        e = sb.pop_front();
        checks++;
        if (done_at !== e.lat) begin
            failures++;
            $display("FAIL mflo_done_cycle: got %0d expected %0d", done_at, e.lat);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== e.lo) begin
            failures++;
            $display("FAIL mflo_read: got stall=%b rdata=%h expected stall=0 rdata=%h",
                     stall, rdata, e.lo);
        end
        lhr_ren = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        push_exp("b2b_first", 32'd0, 32'd15, 33);
        issue(1'b1, 1'b1, 32'd3, 32'd5);
        wait_done(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL b2b_first_done: got %0d expected %0d", lat, e.lat);
        end
        // Next start presented in the FIX cycle must be stalled.
        md_start = 1'b1; md_is_mult = 1'b1; md_is_unsigned = 1'b1;
        op_a = 32'd4; op_b = 32'd9;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fix_stall: got %b expected 1", stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || rdata !== e.lo) begin
            failures++;
            $display("FAIL b2b_idle: got stall=%b busy=%b lo=%h expected 0 0 %h",
                     stall, busy, rdata, e.lo);
        end
        push_exp("b2b_second", 32'd0, 32'd36, 33);
        @(posedge clk);
        #1;
        md_start = 1'b0;
        check_result();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int busy_seen = 0;
`ifdef MD_DIV_EN
        issue(1'b0, 1'b0, 32'd100, 32'd7);
`else
        issue(1'b1, 1'b0, 32'd100, 32'd7);
`endif
        for (int c = 1; c < 10; c++) @(negedge clk);
        rst_n = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_busy: got %b expected 0", busy);
        end
        lhr_is_hi = 1'b1;
        #1;
        checks++;
        if (rdata !== model_hi) begin
            failures++;
            $display("FAIL rst_mid_hi: got %h expected %h", rdata, model_hi);
        end
        lhr_is_hi = 1'b0;
        #1;
        checks++;
        if (rdata !== model_lo) begin
            failures++;
            $display("FAIL rst_mid_lo: got %h expected %h", rdata, model_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (seen != 0 || busy_seen != 0) begin
            failures++;
            $display("FAIL rst_mid_no_done: got done=%0d busy=%0d cycles expected 0 0",
                     seen, busy_seen);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mflo_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
